// File: rtl/bus_arbiter_rr4_if.sv
// Requester/arbiter handshake bundle for the 4-way round-robin bus arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_rr4_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req_i;
  logic [3:0]       gnt_o;
  logic [1:0]       sel_o;
  logic             valid_o;
  logic [CNT_W-1:0] owner_cnt_o;

  modport master (output req_i, input gnt_o, sel_o, valid_o, owner_cnt_o);
  modport slave  (input req_i, output gnt_o, sel_o, valid_o, owner_cnt_o);
endinterface

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter for a shared 4:1 32-bit mux: registered one-hot grant,
// matching mux select, and a tenure limit that applies only under contention.
module bus_arbiter_rr4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bus_arbiter_rr4_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_n;
  logic [3:0]       gnt_q, gnt_n;
  logic [1:0]       sel_q, sel_n;
  logic [1:0]       ptr_q, ptr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             valid_q;
  logic [3:0]       owner_hot;
  logic [3:0]       others;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_hand;

  // Returns {found, index}; scans from start upward modulo 4, first set bit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    owner_hot = 4'b0001 << sel_q;
    // The owner is never a handover candidate, whether it released or was preempted.
    others    = bus.req_i & ~owner_hot;
    pick_idle = rr_pick(bus.req_i, ptr_q);
    pick_hand = rr_pick(others, sel_q + 2'd1);
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << pick_idle[1:0];
          sel_n   = pick_idle[1:0];
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!bus.req_i[sel_q] || (cnt_q >= LIMIT && others != 4'b0000)) begin
          // Release or preemption: advance past the owner and hand over.
          ptr_n = sel_q + 2'd1;
          cnt_n = '0;
          if (pick_hand[2]) begin
            gnt_n = 4'b0001 << pick_hand[1:0];
            sel_n = pick_hand[1:0];
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end else if (cnt_q < LIMIT) begin
          cnt_n = cnt_q + 1'b1;
        end else begin
          cnt_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      sel_q   <= sel_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      valid_q <= (state_n == GRANT);
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.sel_o       = sel_q;
  assign bus.valid_o     = valid_q;
  assign bus.owner_cnt_o = cnt_q;

endmodule
